// File: rtl/pu_riscv_ahb_slave_sram.sv
// AHB-Lite responder backed by a single-port SRAM.
// Zero or more wait states per OKAY transfer, two-cycle ERROR response.
module pu_riscv_ahb_slave_sram #(
    parameter int              XLEN        = 32,
    parameter int              PLEN        = 32,
    parameter logic [PLEN-1:0] BASE_ADDR   = 'h8000_0000,
    parameter int              MEM_SIZE    = 4096,
    parameter int              WAIT_STATES = 0
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic [PLEN-1:0] HADDR,
    input  logic [XLEN-1:0] HWDATA,
    output logic [XLEN-1:0] HRDATA,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [3:0]      HPROT,
    input  logic [1:0]      HTRANS,
    input  logic            HMASTLOCK,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP
);

    localparam int AW    = $clog2(MEM_SIZE);
    localparam int WW    = AW - 2;
    localparam int WORDS = MEM_SIZE / (XLEN / 8);
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam bit ZW    = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] mem [WORDS];
    logic [CW-1:0]   cnt;
    logic [PLEN-1:0] off;
    logic            accept;
    logic            err;
    logic            ok_acc;
    logic [3:0]      be_nxt;

    logic            dp_valid;
    logic            dp_write;
    logic [WW-1:0]   dp_word;
    logic [3:0]      dp_be;
    logic            complete;

    logic            rd_load;
    logic [WW-1:0]   rd_word;
    logic [XLEN-1:0] rd_data;

    logic            unused_sig;

    assign unused_sig = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], off[1:0]};

    // Address-phase decode
    assign off    = HADDR - BASE_ADDR;
    assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign err    = (|off[PLEN-1:AW])
                  | (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (|HADDR[1:0]));
    assign ok_acc = accept & ~err;

    always_comb begin
        be_nxt = 4'hF;
        case (HSIZE)
            3'd0:    be_nxt = 4'b0001 << HADDR[1:0];
            3'd1:    be_nxt = 4'b0011 << HADDR[1:0];
            default: be_nxt = 4'hF;
        endcase
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_ERR2: begin
                if (accept && err)     state_nxt = S_ERR1;
                else if (ok_acc && !ZW) state_nxt = S_WAIT;
                else                   state_nxt = S_IDLE;
            end
            S_WAIT:  state_nxt = (cnt == CW'(1)) ? S_IDLE : S_WAIT;
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        unique case (state)
            S_WAIT:  HREADYOUT = 1'b0;
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2:  HRESP = 1'b1;
            default: HREADYOUT = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)
            cnt <= '0;
        else if (ok_acc && !ZW)
            cnt <= CW'(WAIT_STATES);
        else if (state == S_WAIT)
            cnt <= cnt - CW'(1);
    end

    // Data-phase bookkeeping for the accepted OKAY transfer
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_word  <= '0;
            dp_be    <= '0;
        end else if (ok_acc) begin
            dp_valid <= 1'b1;
            dp_write <= HWRITE;
            dp_word  <= off[AW-1:2];
            dp_be    <= be_nxt;
        end else if (complete) begin
            dp_valid <= 1'b0;
        end
    end

    assign complete = dp_valid & (state == S_IDLE);

    always_ff @(posedge HCLK) begin
        if (!HRESET && complete && dp_write) begin
            for (int b = 0; b < 4; b++)
                if (dp_be[b]) mem[dp_word][b*8 +: 8] <= HWDATA[b*8 +: 8];
        end
    end

    // Zero-wait reads fetch at accept; otherwise on the last wait cycle
    assign rd_load = ZW ? (ok_acc & ~HWRITE)
                        : ((state == S_WAIT) & (cnt == CW'(1))
                           & dp_valid & ~dp_write);
    assign rd_word = ZW ? off[AW-1:2] : dp_word;

    always_comb begin
        rd_data = mem[rd_word];
        if (complete && dp_write && (dp_word == rd_word)) begin
            for (int b = 0; b < 4; b++)
                if (dp_be[b]) rd_data[b*8 +: 8] = HWDATA[b*8 +: 8];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)       HRDATA <= '0;
        else if (rd_load) HRDATA <= rd_data;
    end

endmodule

// File: tb/tb_pu_riscv_ahb_slave_sram.sv
// Scoreboard bench: instance 0 has no wait states, instance 1 has two.
module tb_pu_riscv_ahb_slave_sram;

    typedef struct {
        logic        resp;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel      [2];
    logic        hwrite    [2];
    logic        hmastlock [2];
    logic        block     [2];
    logic [31:0] haddr     [2];
    logic [31:0] hwdata    [2];
    logic [31:0] hrdata    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [3:0]  hprot     [2];
    logic [1:0]  htrans    [2];
    logic        hready    [2];
    logic        hreadyout [2];
    logic        hresp     [2];

    logic [31:0] last_rd [2];
    exp_t        sb [$];
    exp_t        me;
    bit          dp [2];
    int          wc [2];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign hready[g] = hreadyout[g] & ~block[g];
        pu_riscv_ahb_slave_sram #(
            .WAIT_STATES(g * 2)
        ) u_dut (
            .HCLK     (clk),
            .HRESET   (hreset),
            .HSEL     (hsel[g]),
            .HADDR    (haddr[g]),
            .HWDATA   (hwdata[g]),
            .HRDATA   (hrdata[g]),
            .HWRITE   (hwrite[g]),
            .HSIZE    (hsize[g]),
            .HBURST   (hburst[g]),
            .HPROT    (hprot[g]),
            .HTRANS   (htrans[g]),
            .HMASTLOCK(hmastlock[g]),
            .HREADY   (hready[g]),
            .HREADYOUT(hreadyout[g]),
            .HRESP    (hresp[g])
        );
    end

    task automatic chk(input string name, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, i, act, exp);
        end
    endtask

    // Monitor: retire one expected response per completed data phase
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (hreset) begin
                if (dp[i] && sb.size() > 0) void'(sb.pop_front());
                dp[i] = 1'b0;
                wc[i] = 0;
            end else begin
                if (dp[i]) begin
                    if (sb.size() == 0) begin
                        chk("underflow", i, 32'd1, 32'd0);
                        dp[i] = 1'b0;
                    end else if (!hreadyout[i]) begin
                        wc[i]++;
                        chk("stall_resp", i, 32'(hresp[i]), 32'(sb[0].resp));
                    end else begin
                        me = sb.pop_front();
                        chk("resp", i, 32'(hresp[i]), 32'(me.resp));
                        chk("rdata", i, hrdata[i], me.data);
                        chk("waits", i, wc[i], me.waits);
                        wc[i] = 0;
                    end
                end
                if (hreadyout[i])
                    dp[i] = hsel[i] & hready[i] & htrans[i][1];
            end
        end
    end

    task automatic xfer(input int i, input logic [31:0] addr,
                        input logic wr, input logic [2:0] size,
                        input logic [1:0] trans, input logic [31:0] wd,
                        input logic resp, input logic [31:0] rexp);
        int   n;
        exp_t e;
        hsel[i]   = 1'b1;
        haddr[i]  = addr;
        hwrite[i] = wr;
        hsize[i]  = size;
        htrans[i] = trans;
        n = 0;
        @(negedge clk);
        while (!hready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", i, 32'd1, 32'd0);
        if (!wr && !resp) last_rd[i] = rexp;
        e.resp  = resp;
        e.data  = last_rd[i];
        e.waits = resp ? 1 : i * 2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        hwdata[i] = wd;
    endtask

    task automatic idle(input int i, input int n);
        hsel[i]   = 1'b0;
        htrans[i] = 2'd0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] B = 32'h8000_0000;

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            hsel[i] = 0; hwrite[i] = 0; hmastlock[i] = 0; block[i] = 0;
            haddr[i] = B; hwdata[i] = 0; hsize[i] = 3'd2; hburst[i] = 0;
            hprot[i] = 0; htrans[i] = 0; last_rd[i] = 0; dp[i] = 0; wc[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 hreset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, 32'(hreadyout[i]), 32'd1);
            chk("rst_resp", i, 32'(hresp[i]), 32'd0);
            chk("rst_rdata", i, hrdata[i], 32'd0);
        end
        @(posedge clk);
        #1;

        // zero-wait instance: bypass, lanes, errors
        xfer(0, B + 'h10, 1, 3'd2, 2'd2, 32'hDEADBEEF, 0, 0);
        xfer(0, B + 'h10, 0, 3'd2, 2'd2, 32'h0, 0, 32'hDEADBEEF);
        xfer(0, B + 'h10, 1, 3'd2, 2'd2, 32'h11223344, 0, 0);
        xfer(0, B + 'h11, 1, 3'd0, 2'd2, 32'h0000A500, 0, 0);
        xfer(0, B + 'h10, 0, 3'd2, 2'd2, 32'h0, 0, 32'h1122A544);
        xfer(0, B + 'h12, 1, 3'd1, 2'd2, 32'hBEEF0000, 0, 0);
        xfer(0, B + 'h10, 0, 3'd2, 2'd3, 32'h0, 0, 32'hBEEFA544);
        xfer(0, B + 'h00, 1, 3'd2, 2'd2, 32'hCAFEF00D, 0, 0);
        xfer(0, B + 'h1000, 0, 3'd2, 2'd2, 32'h0, 1, 0);
        xfer(0, B + 'h02, 0, 3'd2, 2'd2, 32'h0, 1, 0);
        xfer(0, B + 'h02, 1, 3'd2, 2'd2, 32'hFFFFFFFF, 1, 0);
        xfer(0, B + 'h00, 0, 3'd2, 2'd2, 32'h0, 0, 32'hCAFEF00D);
        xfer(0, B + 'h00, 0, 3'd3, 2'd2, 32'h0, 1, 0);
        xfer(0, B + 'h11, 0, 3'd1, 2'd2, 32'h0, 1, 0);
        xfer(0, B - 'h4, 0, 3'd2, 2'd2, 32'h0, 1, 0);
        xfer(0, B + 'h1010, 1, 3'd2, 2'd2, 32'hFFFFFFFF, 1, 0);
        xfer(0, B + 'h10, 0, 3'd2, 2'd2, 32'h0, 0, 32'hBEEFA544);
        idle(0, 3);

        // selected IDLE, BUSY, and NONSEQ while another slave stalls
        hsel[0] = 1; haddr[0] = B + 'h10; hwrite[0] = 1; hsize[0] = 3'd2;
        hwdata[0] = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            htrans[0] = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : 2'd2;
            block[0]  = (k >= 2);
            @(negedge clk);
            chk("noacc_ready", 0, 32'(hreadyout[0]), 32'd1);
            chk("noacc_resp", 0, 32'(hresp[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        block[0] = 0;
        idle(0, 2);
        xfer(0, B + 'h10, 0, 3'd2, 2'd2, 32'h0, 0, 32'hBEEFA544);
        idle(0, 3);

        // two-wait instance: NONSEQ then SEQ reads, byte write, error
        xfer(1, B + 'h20, 1, 3'd2, 2'd2, 32'h55AA1234, 0, 0);
        xfer(1, B + 'h24, 1, 3'd2, 2'd3, 32'h0BADCAFE, 0, 0);
        xfer(1, B + 'h20, 0, 3'd2, 2'd2, 32'h0, 0, 32'h55AA1234);
        xfer(1, B + 'h24, 0, 3'd2, 2'd3, 32'h0, 0, 32'h0BADCAFE);
        xfer(1, B + 'h23, 1, 3'd0, 2'd2, 32'h77000000, 0, 0);
        xfer(1, B + 'h20, 0, 3'd2, 2'd2, 32'h0, 0, 32'h77AA1234);
        xfer(1, B + 'h2000, 0, 3'd2, 2'd2, 32'h0, 1, 0);
        idle(1, 6);

        // reset during a wait-state data phase abandons the write
        xfer(1, B + 'h20, 1, 3'd2, 2'd2, 32'hFFFFFFFF, 0, 0);
        hsel[1] = 0;
        htrans[1] = 2'd0;
        hreset = 1'b1;
        @(posedge clk);
        #1 hreset = 1'b0;
        @(negedge clk);
        chk("rst_wait_ready", 1, 32'(hreadyout[1]), 32'd1);
        chk("rst_wait_resp", 1, 32'(hresp[1]), 32'd0);
        @(posedge clk);
        #1;
        last_rd[1] = 32'h0;
        xfer(1, B + 'h20, 0, 3'd2, 2'd2, 32'h0, 0, 32'h77AA1234);
        idle(1, 2);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 0, sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pu_riscv_ahb_slave_sram.md
Name: pu_riscv_ahb_slave_sram

Overview:
- AHB-Lite slave (responder) with a single-port SRAM inside. It is the far end of the PU instruction and data AHB4 master ports.
- Used as boot/test memory in PU testbenches and small SoCs.
- Decodes a transfer in the address phase, runs an optional wait-state counter, and completes with an OKAY or a two-cycle ERROR response.
- Bursts are handled as back-to-back single transfers.

Parameters:
- XLEN, 32, data bus width in bits; only 32 is supported.
- PLEN, 32, address bus width in bits.
- BASE_ADDR, 'h8000_0000, first byte address of the memory.
- MEM_SIZE, 4096, memory size in bytes; must be a power of 2 and a multiple of XLEN/8.
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in every OKAY data phase.

Ports:
- HCLK  input  1  clock; all logic is on the rising edge.
- HRESET  input  1  synchronous, active-high reset.
- HSEL  input  1  slave select.
- HADDR  input  PLEN  byte address.
- HWDATA  input  XLEN  write data, valid in the data phase.
- HRDATA  output  XLEN  read data.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size: 0 = byte, 1 = half, 2 = word.
- HBURST  input  3  burst type; ignored.
- HPROT  input  4  protection; ignored.
- HTRANS  input  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- HMASTLOCK  input  1  lock; ignored.
- HREADY  input  1  bus-level ready (previous transfer complete).
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset values: HREADYOUT = 1, HRESP = 0, HRDATA = 0, state = IDLE, wait counter = 0, no pending write. Memory contents are not reset.
- Reset mid-transfer: the transfer is abandoned, no memory write happens, and the outputs return to their reset values on the next cycle.
- Accept condition: HSEL & HREADY & HTRANS[1]. All address-phase signals are registered on accept. IDLE, BUSY, or an unselected cycle gives a zero-wait OKAY and never touches memory.
- Address offset: off = HADDR - BASE_ADDR, PLEN-bit unsigned, so addresses below base wrap to large values.
- Error detect (evaluated at accept):
  - off >= MEM_SIZE, or
  - HSIZE > 2, or
  - HSIZE = 1 with HADDR[0] != 0, or
  - HSIZE = 2 with HADDR[1:0] != 0.
- States:
  - IDLE: on accept with error go to ERR1. On accept with no error and WAIT_STATES > 0, load counter = WAIT_STATES and go to WAIT. Otherwise stay in IDLE; the transfer then completes in the next cycle with HREADYOUT = 1, HRESP = 0.
  - WAIT: HREADYOUT = 0, HRESP = 0. Counter decrements each cycle. When counter = 1, the next cycle completes the transfer (HREADYOUT = 1) and the state returns to IDLE. A new accept in that completing cycle is processed exactly as from IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1; always goes to ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1, then IDLE. A new accept in ERR2 is processed as from IDLE.
- Write:
  - Happens in the completing data-phase cycle, using HWDATA at that cycle.
  - Little-endian byte enables: byte = 1 << a[1:0]; half = 3 << a[1:0]; word = 4'hF.
  - Errored transfers never write.
- Read:
  - The SRAM is read using the registered word address. HRDATA is loaded on the completing cycle and always carries the full aligned word; the master selects lanes.
  - HRDATA holds its value between reads; writes and errors leave it unchanged.
- Write-to-read bypass:
  - With WAIT_STATES = 0 and a read accepted while the previous write completes to the same word, the enabled bytes of HWDATA are merged into the read data.
  - The read returns the new bytes, with zero latency penalty.
- Latency: an OKAY transfer completes (WAIT_STATES + 1) cycles after accept. An ERROR transfer completes 2 cycles after accept.
- Back-to-back: with WAIT_STATES = 0, a new transfer can be accepted every cycle, giving full pipeline throughput.
- HBURST, HPROT, HMASTLOCK: no effect. SEQ is treated exactly like NONSEQ.

Test Plan:
- Reset, then idle bus -> HREADYOUT = 1, HRESP = 0, HRDATA = 0. Assert HRESET during a WAIT data phase -> next cycle HREADYOUT = 1 and the memory word is unchanged.
- WAIT_STATES = 0: word write 'hDEADBEEF at 'h8000_0010, then a word read at 'h8000_0010 on the very next address phase -> HRDATA = 'hDEADBEEF (bypass), no stall.
- Byte write 'hxx_xx_A5_xx (lane 1) to 'h8000_0011 over word 'h11223344, then word read -> 'h1122A544. Halfword write 'hBEEF to 'h8000_0012 -> word read gives 'hBEEFA544.
- Out-of-range read at 'h8000_1000 (MEM_SIZE 4096), and misaligned word read at 'h8000_0002 -> HREADYOUT 0 then 1 with HRESP = 1 for both cycles, and memory is unchanged after an errored write to the same address.
- WAIT_STATES = 2: read NONSEQ followed by SEQ -> each data phase holds HREADYOUT = 0 for exactly 2 cycles, data is correct on the third cycle, and the address is held stable by the master throughout.
- IDLE and BUSY cycles with HSEL = 1, and a NONSEQ with HREADY = 0 driven by another slave -> no accept, HREADYOUT = 1, HRESP = 0, memory unchanged.
